fpadd_shifter_arbiter: RTL and testbench

- Shares one signed-shift barrel shifter between two FP add/sub requesters:
  - alignment: right-shifts the smaller mantissa by the exponent difference;
  - normalization: left-shifts the result by the leading-zero count.
- Arbitrates round-robin, registers the shifter operands, captures the result and returns it with a response handshake.
- The combinational shifter instance sits outside this block; this block drives its operand pins and samples its result.

---
 rtl/fpadd_shifter_pkg.sv | 17 +
 rtl/fpadd_shifter_arbiter_if.sv | 33 +++
 rtl/fpadd_rr_arb2.sv | 29 ++
 rtl/fpadd_shifter_arbiter.sv | 114 +++++++++++
 tb/tb_fpadd_shifter_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fpadd_shifter_pkg.sv
// Shared types and constants for the FP add/sub shifter arbiter.
package fpadd_shifter_pkg;

  localparam int W_DEF  = 26;
  localparam int SW_DEF = 5;

  // Owner tags double as arbiter request/grant bit indices.
  localparam logic TAG_ALIGN = 1'b0;
  localparam logic TAG_NORM  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/fpadd_shifter_arbiter_if.sv
// Request/response bundle between the two FP add/sub requesters and the shifter arbiter.
interface fpadd_shifter_arbiter_if
  import fpadd_shifter_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) ();

  logic          a_req_valid;
  logic          a_req_ready;
  logic [W-1:0]  a_data;
  logic [SW-1:0] a_amt;
  logic          n_req_valid;
  logic          n_req_ready;
  logic [W-1:0]  n_data;
  logic [SW-1:0] n_amt;
  logic          a_rsp_valid;
  logic          n_rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_sticky;

  modport master (
    output a_req_valid, a_data, a_amt, n_req_valid, n_data, n_amt, rsp_ready,
    input  a_req_ready, n_req_ready, a_rsp_valid, n_rsp_valid, rsp_data, rsp_sticky
  );

  modport slave (
    input  a_req_valid, a_data, a_amt, n_req_valid, n_data, n_amt, rsp_ready,
    output a_req_ready, n_req_ready, a_rsp_valid, n_rsp_valid, rsp_data, rsp_sticky
  );

endinterface

// File: rtl/fpadd_rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers which side won last.
module fpadd_rr_arb2
  import fpadd_shifter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd_en,
  output logic [1:0] gnt
);

  logic last;

  always_ff @(posedge clk) begin
    if (rst)         last <= TAG_NORM;
    else if (upd_en) last <= gnt[TAG_NORM];
  end

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = '0;
      // The side that did not win last time goes first.
      if (last == TAG_NORM) gnt[TAG_ALIGN] = 1'b1;
      else                  gnt[TAG_NORM]  = 1'b1;
    end
  end

endmodule

// File: rtl/fpadd_shifter_arbiter.sv
// Shares one external signed barrel shifter between FP add alignment and normalization.
// Optional FPADD_SHIFTER_STICKY_EN: return the OR of alignment shifted-out bits on rsp_sticky.
module fpadd_shifter_arbiter
  import fpadd_shifter_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  fpadd_shifter_arbiter_if.slave bus,
  output logic [W-1:0]           sh_data_in,
  output logic [SW:0]            sh_amt,
  output logic                   sh_tc,
  output logic                   sh_data_tc,
  output logic                   sh_mode,
  input  logic [W-1:0]           sh_result
);

  localparam logic [SW:0] W_AMT = W[SW:0];

  state_t        state, nxt;
  logic [1:0]    gnt;
  logic          hs;
  logic          owner;
  logic          clamp_q;
  logic [W-1:0]  rsp_data_q;

  assign sh_tc      = 1'b1;
  assign sh_data_tc = 1'b0;
  assign sh_mode    = 1'b1;

  fpadd_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.n_req_valid, bus.a_req_valid}),
    .upd_en (hs),
    .gnt    (gnt)
  );

  // Ready is gated by rst so nothing can be accepted on a reset edge.
  assign bus.a_req_ready = (state == IDLE) & gnt[TAG_ALIGN] & ~rst;
  assign bus.n_req_ready = (state == IDLE) & gnt[TAG_NORM]  & ~rst;
  assign hs              = bus.a_req_ready | bus.n_req_ready;

  assign bus.a_rsp_valid = (state == RESP) & (owner == TAG_ALIGN);
  assign bus.n_rsp_valid = (state == RESP) & (owner == TAG_NORM);
  assign bus.rsp_data    = rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (hs) nxt = ISSUE;
      ISSUE:   nxt = RESP;
      RESP:    if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data_in <= '0;
      sh_amt     <= '0;
      owner      <= TAG_ALIGN;
      clamp_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (hs) begin
        if (gnt[TAG_ALIGN]) begin
          sh_data_in <= bus.a_data;
          sh_amt     <= -{1'b0, bus.a_amt};
          owner      <= TAG_ALIGN;
          clamp_q    <= {1'b0, bus.a_amt} >= W_AMT;
        end else begin
          sh_data_in <= bus.n_data;
          sh_amt     <= {1'b0, bus.n_amt};
          owner      <= TAG_NORM;
          clamp_q    <= {1'b0, bus.n_amt} >= W_AMT;
        end
      end
      // Shifter behaviour past the data width is not relied on.
      if (state == ISSUE) rsp_data_q <= clamp_q ? '0 : sh_result;
    end
  end

`ifdef FPADD_SHIFTER_STICKY_EN
  logic         sticky_q;
  logic         rsp_sticky_q;
  logic [W-1:0] a_lost_mask;

  // Low a_amt bits; a shift past W leaves all ones, covering the clamp case.
  assign a_lost_mask = ~({W{1'b1}} << bus.a_amt);

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q     <= 1'b0;
      rsp_sticky_q <= 1'b0;
    end else begin
      if (hs) sticky_q <= gnt[TAG_ALIGN] & (|(bus.a_data & a_lost_mask));
      if (state == ISSUE) rsp_sticky_q <= sticky_q;
    end
  end

  assign bus.rsp_sticky = rsp_sticky_q;
`else
  assign bus.rsp_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fpadd_shifter_arbiter.sv
// Directed bench for fpadd_shifter_arbiter with a behavioural model of the external shifter.
module tb_fpadd_shifter_arbiter;
  localparam int W  = 26;
  localparam int SW = 5;

`ifdef FPADD_SHIFTER_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpadd_shifter_arbiter_if #(.W(W), .SW(SW)) bus ();

  logic [W-1:0] sh_data_in, sh_result;
  logic [SW:0]  sh_amt;
  logic         sh_tc, sh_data_tc, sh_mode;

  fpadd_shifter_arbiter #(.W(W), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sh_data_in (sh_data_in),
    .sh_amt     (sh_amt),
    .sh_tc      (sh_tc),
    .sh_data_tc (sh_data_tc),
    .sh_mode    (sh_mode),
    .sh_result  (sh_result)
  );

  // Signed amount, negative = logical right shift.
  assign sh_result = sh_amt[SW] ? (sh_data_in >> (-sh_amt)) : (sh_data_in << sh_amt);

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ardy"},  bus.a_req_ready, 0);
    chk({tag, "_nrdy"},  bus.n_req_ready, 0);
    chk({tag, "_vld"},   {bus.a_rsp_valid, bus.n_rsp_valid}, 0);
    chk({tag, "_data"},  bus.rsp_data, 0);
    chk({tag, "_stk"},   bus.rsp_sticky, 0);
    chk({tag, "_shd"},   sh_data_in, 0);
    chk({tag, "_sha"},   sh_amt, 0);
  endtask

  task automatic do_op(input logic nrm, input logic [W-1:0] d, input logic [SW-1:0] amt,
                       input logic [SW:0] x_amt, input logic [W-1:0] x_data, input logic x_stk);
    int t;
    @(negedge clk);
    if (nrm) begin bus.n_req_valid = 1; bus.n_data = d; bus.n_amt = amt; end
    else     begin bus.a_req_valid = 1; bus.a_data = d; bus.a_amt = amt; end
    #1;
    t = 0;
    while (!(nrm ? bus.n_req_ready : bus.a_req_ready) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("grant", t < 20, 1);
    chk("rdy_excl", nrm ? bus.a_req_ready : bus.n_req_ready, 0);
    @(posedge clk); #1;
    bus.a_req_valid = 0;
    bus.n_req_valid = 0;
    @(negedge clk);
    chk("iss_amt",  sh_amt, x_amt);
    chk("iss_data", sh_data_in, d);
    chk("iss_vld",  bus.a_rsp_valid | bus.n_rsp_valid, 0);
    chk("iss_rdy",  bus.a_req_ready | bus.n_req_ready, 0);
    @(negedge clk);
    chk("rsp_own",  nrm ? bus.n_rsp_valid : bus.a_rsp_valid, 1);
    chk("rsp_oth",  nrm ? bus.a_rsp_valid : bus.n_rsp_valid, 0);
    chk("rsp_data", bus.rsp_data, x_data);
    chk("rsp_stk",  bus.rsp_sticky, x_stk);
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    @(negedge clk);
    chk("rsp_drop", bus.a_rsp_valid | bus.n_rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] held;
    rst = 1;
    bus.a_req_valid = 0; bus.a_data = '0; bus.a_amt = '0;
    bus.n_req_valid = 0; bus.n_data = '0; bus.n_amt = '0;
    bus.rsp_ready = 0;
    repeat (2) @(negedge clk);
    chk_zero_outs("rst");
    chk("sh_const", {sh_tc, sh_data_tc, sh_mode}, 3'b101);
    rst = 0;

    // Single-requester operations, including clamp and zero-shift boundaries
    do_op(0, 26'h3FFFFFF, 5'd4,  6'h3C, 26'h03FFFFF, STK);
    do_op(1, 26'h0000100, 5'd17, 6'h11, 26'h2000000, 1'b0);
    do_op(0, 26'h0000001, 5'd30, 6'h22, 26'h0000000, STK);
    do_op(0, 26'h1234567, 5'd0,  6'h00, 26'h1234567, 1'b0);
    do_op(0, 26'h3000000, 5'd25, 6'h27, 26'h0000001, STK);
    do_op(1, 26'h0000001, 5'd26, 6'h1A, 26'h0000000, 1'b0);

    // Backpressure with a norm request waiting
    @(negedge clk);
    bus.a_req_valid = 1; bus.a_data = 26'h2AAAAAA; bus.a_amt = 5'd1;
    #1 chk("bp_ardy", bus.a_req_ready, 1);
    @(posedge clk); #1;
    bus.a_req_valid = 0;
    bus.n_req_valid = 1; bus.n_data = 26'h0000003; bus.n_amt = 5'd2;
    repeat (2) @(negedge clk);
    held = bus.rsp_data;
    chk("bp_first", held, 26'h1555555);
    for (int c = 0; c < 5; c++) begin
      chk("bp_vld",  bus.a_rsp_valid, 1);
      chk("bp_data", bus.rsp_data, 26'h1555555);
      chk("bp_stk",  bus.rsp_sticky, 0);
      chk("bp_rdy",  bus.a_req_ready | bus.n_req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    @(negedge clk);
    chk("bp_drop", bus.a_rsp_valid, 0);
    chk("bp_nrdy", bus.n_req_ready, 1);
    @(posedge clk); #1;
    bus.n_req_valid = 0;
    repeat (2) @(negedge clk);
    chk("bp_nvld",  bus.n_rsp_valid, 1);
    chk("bp_ndata", bus.rsp_data, 26'h000000C);
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;

    // Round robin from reset with both requesters always pending
    @(negedge clk);
    rst = 1;
    bus.a_req_valid = 1; bus.a_data = 26'h0000010; bus.a_amt = 5'd2;
    bus.n_req_valid = 1; bus.n_data = 26'h0000001; bus.n_amt = 5'd1;
    bus.rsp_ready = 1;
    @(negedge clk);
    rst = 0;
    #1;
    for (int c = 0; c < 12; c++) begin
      int g;
      g = c / 3;
      chk("rr_a", bus.a_req_ready, (c % 3 == 0) && (g % 2 == 0));
      chk("rr_n", bus.n_req_ready, (c % 3 == 0) && (g % 2 == 1));
      if (c % 3 == 2) chk("rr_own", bus.a_rsp_valid, g % 2 == 0);
      @(negedge clk); #1;
    end
    bus.a_req_valid = 0;
    bus.n_req_valid = 0;
    bus.rsp_ready = 0;

    // Reset during ISSUE
    @(negedge clk);
    bus.a_req_valid = 1; bus.a_data = 26'h00000F0; bus.a_amt = 5'd4;
    #1 chk("r6_ardy", bus.a_req_ready, 1);
    @(posedge clk); #1;
    bus.a_req_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_zero_outs("r6i");
    rst = 0;
    bus.a_req_valid = 1;
    bus.n_req_valid = 1;
    #1;
    chk("r6i_ga", bus.a_req_ready, 1);
    chk("r6i_gn", bus.n_req_ready, 0);
    @(posedge clk); #1;
    bus.a_req_valid = 0;
    bus.n_req_valid = 0;

    // Reset during RESP
    repeat (2) @(negedge clk);
    chk("r6r_vld", bus.a_rsp_valid, 1);
    rst = 1;
    @(negedge clk);
    chk_zero_outs("r6r");
    rst = 0;
    repeat (2) begin
      @(negedge clk);
      chk("r6r_quiet", bus.a_rsp_valid | bus.n_rsp_valid, 0);
    end
    bus.a_req_valid = 1;
    bus.n_req_valid = 1;
    #1;
    chk("r6r_ga", bus.a_req_ready, 1);
    chk("r6r_gn", bus.n_req_ready, 0);
    @(posedge clk); #1;
    bus.a_req_valid = 0;
    bus.n_req_valid = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
